chacha_stream_xor: RTL and testbench
====================================

Name: chacha_stream_xor

Overview:
- Keystream consumer that sits on the output side of chacha_core.
- Drives the core's init/next controls and captures each 512-bit keystream block.
- XORs the block word-by-word onto a valid/ready data stream, so one block serves both encryption and decryption.
- Requests a fresh block whenever the current one is exhausted mid-message.

Parameters:
- WORD_W, 32: data word width; must divide 512. WORDS = 512/WORD_W words per keystream block.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  pulse: begin a new message (core key/iv/ctr already set up externally)
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid && in_ready
- in_data  in  WORD_W  plaintext/ciphertext word
- in_last  in  1  marks final word of message
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accept
- out_data  out  WORD_W  in_data XOR keystream word
- out_last  out  1  copy of in_last for this word
- core_init  out  1  one-cycle pulse to chacha_core init
- core_next  out  1  one-cycle pulse to chacha_core next
- core_ready  in  1  chacha_core ready
- core_data  in  512  chacha_core data_out
- core_valid  in  1  chacha_core data_out_valid
- busy  out  1  high from accepted start until the last output word is consumed
- blk_count  out  16  keystream blocks captured in the current message; wraps at 16 bits

Behaviour:
- Reset (reset_n low at a clk edge), from any state, including mid-message:
  - state = IDLE.
  - All outputs 0: in_ready, out_valid, out_data, out_last, core_init, core_next, busy, blk_count.
  - Keystream buffer and word index cleared.
- Word order: word k is core_data[511-k*WORD_W -: WORD_W]. Word 0 is the MSBs.
- Core contract: chacha_core clears data_out_valid within one cycle of an init/next pulse.
- FSM states and transitions:
  - IDLE:
    - start=1 → REQ; set first=1, blk_count=0, busy=1.
    - start is ignored in every other state.
  - REQ:
    - Wait for core_ready=1.
    - On that cycle assert core_init for one cycle if first=1, else core_next for one cycle.
    - Clear first; → WAIT.
  - WAIT:
    - core_valid is ignored on the first WAIT cycle.
    - Afterwards, when core_valid=1: load core_data into the buffer, idx=0, blk_count+1, → STREAM.
  - STREAM:
    - in_ready = !out_valid || out_ready. It is 0 in every other state.
    - On an input handshake: out_data ← in_data ^ word[idx], out_last ← in_last, out_valid ← 1, idx+1.
    - If in_last: → IDLE.
    - Else if idx was WORDS-1: → REQ (next block).
    - in_last has priority when both hold; no spare block is requested.
- Output register:
  - out_valid drops when out_ready=1 and no new word is loaded in the same cycle.
  - out_data and out_last stay stable while out_valid && !out_ready.
  - Throughput is one word/cycle in STREAM with out_ready held high.
- busy:
  - Stays high in IDLE while out_valid=1 (final word still draining).
  - Falls the cycle after the last output handshake.
- Latency: input word to out_valid is 1 cycle.
- Block boundary: the bubble between blocks equals core compute latency plus 2 cycles; no words are lost or duplicated.
- core_init and core_next are never high together. Each is never high for 2 consecutive cycles.

Test Plan:
- Reset: hold reset_n low 2 cycles with in_valid=1 and start=1 → all outputs 0, in_ready 0, no core pulses.
- Single word:
  - Stimulus: start; core model returns all-0xAA block 10 cycles after init; in_data=0x12345678, in_last=1.
  - Required: out_data=0xB89EFCD2, out_last=1, exactly one core_init, zero core_next, blk_count=1, busy low after drain.
- 17-word message (WORD_W=32):
  - Stimulus: block0 all-0x11111111, block1 all-0x22222222; input words 0..16 carry value = index.
  - Required: words 0-15 XOR 0x11111111; word 16 = 0x00000010^0x22222222 = 0x22222232.
  - Required: one core_init, then exactly one core_next, blk_count=2.
- Backpressure: out_ready low 5 cycles mid-block → in_ready 0, out_data unchanged, no index advance. Release → stream continues in order.
- Start while busy and reset mid-STREAM:
  - Extra start pulse → ignored.
  - reset_n low during STREAM → IDLE, outputs 0.
  - Next start → core_init, not core_next.
- Round trip: a 40-word random message XORed twice with the same core model → original data, out_last only on word 40.

Source files
------------

// File: rtl/chacha_stream_xor.sv
// chacha_stream_xor
//   Keystream consumer placed after chacha_core. It requests keystream
//   blocks (init for the first block of a message, next for each later one)
//   and captures each 512-bit block. It then XORs the block word by word onto
//   a valid/ready stream. Because the operation is an XOR, the same path both
//   encrypts and decrypts.
//
// Ports
//   clk, reset_n           : clock; synchronous active-low reset
//   start                  : pulse that begins a message (accepted in IDLE only)
//   in_valid/in_ready      : input word handshake; in_data, in_last
//   out_valid/out_ready    : output word handshake; out_data, out_last
//   core_init/core_next    : one-cycle request pulses to chacha_core
//   core_ready/core_valid  : chacha_core status; core_data = 512-bit block
//   busy                   : start accepted .. last output word consumed
//   blk_count              : keystream blocks captured in this message
module chacha_stream_xor #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              core_init,
  output logic              core_next,
  input  logic              core_ready,
  input  logic [511:0]      core_data,
  input  logic              core_valid,
  output logic              busy,
  output logic [15:0]       blk_count
);
  localparam int WORDS = 512 / WORD_W;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, STREAM} state_e;

  state_e              state_q, state_d;
  logic                first_q, first_d;
  logic                wait1_q, wait1_d;
  logic [511:0]        buf_q, buf_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                out_valid_q, out_valid_d;
  logic [WORD_W-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic                busy_q, busy_d;
  logic [15:0]         blk_count_q, blk_count_d;
  logic                in_hs;

  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    wait1_d     = wait1_q;
    buf_d       = buf_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    blk_count_d = blk_count_q;
    core_init   = 1'b0;
    core_next   = 1'b0;

    in_ready = (state_q == STREAM) && (!out_valid_q || out_ready);
    in_hs    = in_valid && in_ready;

    // The output register empties on accept; a load below overrides this.
    if (out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = REQ;
          first_d     = 1'b1;
          blk_count_d = '0;
          busy_d      = 1'b1;
        end else if (!out_valid_q || out_ready) begin
          // The final word may still be draining after the message ends.
          busy_d = 1'b0;
        end
      end
      REQ: begin
        if (core_ready) begin
          core_init = first_q;
          core_next = !first_q;
          first_d   = 1'b0;
          wait1_d   = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        // core_valid may still reflect the previous block for one cycle.
        if (wait1_q) begin
          wait1_d = 1'b0;
        end else if (core_valid) begin
          buf_d       = core_data;
          idx_d       = '0;
          blk_count_d = blk_count_q + 16'd1;
          state_d     = STREAM;
        end
      end
      STREAM: begin
        if (in_hs) begin
          // The buffer shifts left so that the current word is always at the MSBs.
          out_data_d  = in_data ^ buf_q[511 -: WORD_W];
          buf_d       = buf_q << WORD_W;
          out_last_d  = in_last;
          out_valid_d = 1'b1;
          idx_d       = idx_q + 1'b1;
          if (in_last)                               state_d = IDLE;
          else if (idx_q == IDX_W'(WORDS - 1))       state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      first_q     <= 1'b0;
      wait1_q     <= 1'b0;
      buf_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      blk_count_q <= '0;
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      wait1_q     <= wait1_d;
      buf_q       <= buf_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      blk_count_q <= blk_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign blk_count = blk_count_q;
endmodule

// File: tb/tb_chacha_stream_xor.sv
// Testbench for chacha_stream_xor. It contains a behavioural chacha_core stand-in
// that returns programmable blocks after a programmable latency. A scoreboard
// queue holds the expected output words, and a monitor pops and compares them.
module tb_chacha_stream_xor;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  out_data;
  logic         out_last;
  logic         core_init, core_next;
  logic         core_ready = 1'b1;
  logic [511:0] core_data = '0;
  logic         core_valid = 1'b0;
  logic         busy;
  logic [15:0]  blk_count;

  chacha_stream_xor #(.WORD_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .core_init(core_init), .core_next(core_next), .core_ready(core_ready),
    .core_data(core_data), .core_valid(core_valid),
    .busy(busy), .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [511:0] ks_blk [4];
  logic [31:0]  msg_in [64];
  logic [31:0]  orig   [64];
  logic [32:0]  exp_q [$];
  logic [31:0]  cap_q [$];
  logic         sb_en = 1'b1;
  int           rdy_mode = 0;
  int           core_lat = 4;
  int           init_cnt = 0, next_cnt = 0, proto_err = 0;
  logic         prev_init = 1'b0, prev_next = 1'b0;

  // chacha_core stand-in: init restarts at block 0, next advances one block.
  int bi = 0, cnt = 0;
  always @(posedge clk) begin
    if (core_init || core_next) begin
      bi <= core_init ? 0 : bi + 1;
      cnt <= core_lat;
      core_valid <= 1'b0;
      core_ready <= 1'b0;
    end else if (cnt == 1) begin
      cnt <= 0;
      core_valid <= 1'b1;
      core_ready <= 1'b1;
      core_data <= ks_blk[bi & 3];
    end else if (cnt > 1) begin
      cnt <= cnt - 1;
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // The monitor samples on the falling edge. An output handshake seen here
  // completes at the next rising edge.
  always @(negedge clk) begin
    logic [32:0] e;
    if (core_init && core_next) proto_err++;
    if ((core_init && prev_init) || (core_next && prev_next)) proto_err++;
    prev_init = core_init;
    prev_next = core_next;
    if (core_init) init_cnt++;
    if (core_next) next_cnt++;
    if (sb_en && out_valid && out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got %h/%0b, none expected", out_data, out_last);
      end else begin
        e = exp_q.pop_front();
        if ({out_last, out_data} !== e) begin
          fails++;
          $display("FAIL sb_word: got last=%0b data=%h expected last=%0b data=%h",
                   out_last, out_data, e[32], e[31:0]);
        end
      end
      cap_q.push_back(out_data);
    end
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Keystream word k of a message: block k/16, with word 0 at the MSBs.
  function automatic logic [31:0] ks_word(int k);
    logic [511:0] b;
    b = ks_blk[k / 16];
    return b[511 - (k % 16) * 32 -: 32];
  endfunction

  task automatic rand_blocks();
    for (int b = 0; b < 4; b++)
      for (int w = 0; w < 16; w++) ks_blk[b][w*32 +: 32] = $urandom;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_msg(int n);
    int t;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({(k == n - 1), msg_in[k] ^ ks_word(k)});
      in_valid = 1'b1;
      in_data  = msg_in[k];
      in_last  = (k == n - 1);
      t = 0;
      do begin @(negedge clk); t++; end while (!in_ready && t < 1000);
      if (!in_ready) begin
        tests++; fails++;
        $display("FAIL in_timeout: word %0d not accepted", k);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 2000) begin @(negedge clk); t++; end
    chk("drain_busy", {63'd0, busy}, 64'd0);
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int i0, n0, t;
    logic [31:0] snap;
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i0, n0, t;
    logic [31:0] snap;
    // Reset with stimulus active.
    in_valid = 1'b1; start = 1'b1; in_data = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 0);
    chk("rst_out_valid", {63'd0, out_valid}, 0);
    chk("rst_out_data", {32'd0, out_data}, 0);
    chk("rst_out_last", {63'd0, out_last}, 0);
    chk("rst_busy", {63'd0, busy}, 0);
    chk("rst_blk_count", {48'd0, blk_count}, 0);
    chk("rst_core_pulses", 64'(init_cnt + next_cnt), 0);
    @(posedge clk); #1;
    in_valid = 1'b0; start = 1'b0; reset_n = 1'b1;
    @(posedge clk); #1;

    // Single word.
    for (int b = 0; b < 4; b++) ks_blk[b] = {16{32'hAAAAAAAA}};
    core_lat = 10; cap_q.delete();
    i0 = init_cnt; n0 = next_cnt;
    msg_in[0] = 32'h12345678;
    do_start();
    send_msg(1);
    wait_drain();
    chk("single_count", 64'(cap_q.size()), 1);
    if (cap_q.size() > 0) chk("single_data", {32'd0, cap_q[0]}, 64'hB89EFCD2);
    chk("single_init", 64'(init_cnt - i0), 1);
    chk("single_next", 64'(next_cnt - n0), 0);
    chk("single_blk", {48'd0, blk_count}, 1);

    // 17 words across a block boundary. A second start mid-message must be ignored.
    ks_blk[0] = {16{32'h11111111}};
    ks_blk[1] = {16{32'h22222222}};
    core_lat = 3; cap_q.delete();
    i0 = init_cnt; n0 = next_cnt;
    for (int k = 0; k < 17; k++) msg_in[k] = k;
    do_start();
    fork
      send_msg(17);
      begin
        t = 0;
        while (cap_q.size() < 5 && t < 500) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    wait_drain();
    chk("m17_count", 64'(cap_q.size()), 17);
    if (cap_q.size() == 17) begin
      chk("m17_w0", {32'd0, cap_q[0]}, 64'h11111111);
      chk("m17_w15", {32'd0, cap_q[15]}, 64'h1111111E);
      chk("m17_w16", {32'd0, cap_q[16]}, 64'h22222232);
    end
    chk("m17_init", 64'(init_cnt - i0), 1);
    chk("m17_next", 64'(next_cnt - n0), 1);
    chk("m17_blk", {48'd0, blk_count}, 2);

    // Backpressure: out_ready is held low for 5 cycles in the middle of a block.
    rand_blocks(); core_lat = 2; cap_q.delete();
    for (int k = 0; k < 8; k++) msg_in[k] = $urandom;
    do_start();
    fork
      send_msg(8);
      begin
        t = 0;
        while (cap_q.size() < 3 && t < 500) begin @(negedge clk); t++; end
        @(posedge clk);
        rdy_mode = 2;
        @(negedge clk);
        snap = out_data;
        for (int i = 0; i < 5; i++) begin
          if (i > 0) begin
            @(negedge clk);
            chk("bp_hold", {32'd0, out_data}, {32'd0, snap});
          end
          chk("bp_in_ready", {63'd0, in_ready}, 0);
          chk("bp_out_valid", {63'd0, out_valid}, 1);
        end
        @(posedge clk);
        rdy_mode = 0;
      end
    join
    wait_drain();
    chk("bp_count", 64'(cap_q.size()), 8);

    // Reset in the middle of STREAM, then a fresh start must use init.
    rand_blocks(); core_lat = 3;
    sb_en = 1'b0;
    in_valid = 1'b1; in_data = $urandom; in_last = 1'b0;
    do_start();
    t = 0;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    chk("mid_reach_stream", {63'd0, in_ready}, 1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_out_valid", {63'd0, out_valid}, 0);
    chk("mid_rst_out_data", {32'd0, out_data}, 0);
    chk("mid_rst_in_ready", {63'd0, in_ready}, 0);
    chk("mid_rst_busy", {63'd0, busy}, 0);
    chk("mid_rst_blk", {48'd0, blk_count}, 0);
    @(posedge clk); #1;
    reset_n = 1'b1; in_valid = 1'b0;
    exp_q.delete(); cap_q.delete(); sb_en = 1'b1;
    i0 = init_cnt; n0 = next_cnt;
    for (int k = 0; k < 3; k++) msg_in[k] = $urandom;
    do_start();
    send_msg(3);
    wait_drain();
    chk("after_rst_init", 64'(init_cnt - i0), 1);
    chk("after_rst_next", 64'(next_cnt - n0), 0);

    // Round trip: 40 random words XORed twice return the original data.
    rand_blocks(); core_lat = $urandom_range(1, 6); rdy_mode = 1;
    for (int k = 0; k < 40; k++) begin msg_in[k] = $urandom; orig[k] = msg_in[k]; end
    cap_q.delete();
    do_start();
    send_msg(40);
    wait_drain();
    chk("rt_pass1_count", 64'(cap_q.size()), 40);
    chk("rt_blk", {48'd0, blk_count}, 3);
    for (int k = 0; k < 40 && k < cap_q.size(); k++) msg_in[k] = cap_q[k];
    cap_q.delete();
    do_start();
    send_msg(40);
    wait_drain();
    chk("rt_pass2_count", 64'(cap_q.size()), 40);
    for (int k = 0; k < 40 && k < cap_q.size(); k++)
      chk("rt_data", {32'd0, cap_q[k]}, {32'd0, orig[k]});
    rdy_mode = 0;

    chk("core_pulse_protocol", 64'(proto_err), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
